mux_16_1_input16bit: RTL and testbench
======================================

MUX_16_1_INPUT16BIT -- requirements
Module: mux_16_1_input16bit

Interface
REQ-001 Parameter WIDTH, default 16: bit width of every data input and of OUT.
REQ-002 Parameter SEL_W, default 4: select width; fixed at 4 for 16 inputs and not user-overridable in practice.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 X0..X15  input  WIDTH each  sixteen data inputs, X<n> is selected by S==n.
REQ-006 S  input  SEL_W  select code, unsigned, 0..15.
REQ-007 OUT  output  WIDTH  registered selected data.

Function
REQ-008 At each rising clk edge with rst low, OUT SHALL load X[S], the input whose index equals unsigned S.
REQ-009 Latency SHALL be exactly one clock cycle from S/X sampled at an edge to OUT valid after that edge; no combinational path from any input to OUT.
REQ-010 All 16 select codes SHALL be decoded; there SHALL be no default or illegal code and no don't-care output.
REQ-011 Selection SHALL be bitwise pass-through: no arithmetic, inversion, sign extension or truncation; OUT[k] equals X[S][k] for every bit k.
REQ-012 A change of S and all X in the same cycle SHALL produce OUT equal to the new X[new S] after the next edge; there SHALL be no stale-data blending.
REQ-013 When S is held constant, OUT SHALL track the selected input with one-cycle delay every cycle; changes on unselected inputs SHALL have no effect on OUT.
REQ-014 Back-to-back select changes on consecutive cycles SHALL each be honoured with no bubbles or holds.

Reset
REQ-015 While rst is high at a rising clk edge, OUT SHALL become all-zero regardless of S and X.
REQ-016 rst SHALL take priority over selection at the same edge.
REQ-017 After rst is deasserted, the first edge SHALL load X[S] normally; no warm-up cycles.
REQ-018 Assertion of rst mid-stream SHALL discard the in-flight selection; OUT SHALL read zero one edge later.
REQ-019 Before the first clock edge OUT is undefined; rst SHALL have no asynchronous effect.

Structure
REQ-020 A shared package SHALL hold the WIDTH and SEL_W defaults and the input count (16).
REQ-021 Selection SHALL be built from one sub-module, mux_4_1, a combinational WIDTH-bit 4:1 mux.
REQ-022 Five mux_4_1 instances SHALL be used: four first-level instances selected by S[1:0], and one second-level instance selected by S[3:2].
REQ-023 The top level SHALL contain the output register with synchronous reset.

Verification
REQ-024 Select sweep: X<n> = one-hot 1<<n (X0=0x0001 .. X15=0x8000); S stepped 0..15, one step per cycle -> OUT equals 1<<S one cycle after each step, e.g. S=5 gives 0x0020 and S=15 gives 0x8000.
REQ-025 Reset: rst=1 with S=3 and X3=0x0008 -> OUT=0x0000 after the edge; rst=0 -> OUT=0x0008 after the next edge.
REQ-026 Unselected-input isolation: S=7 and X7=0xA5A5 held; all other inputs randomized each cycle -> OUT stays 0xA5A5.
REQ-027 Same-cycle change: S goes 2->9 while X9 goes to 0xFFFF in the same cycle -> OUT=0xFFFF one edge later, with no intermediate value.
REQ-028 Reset mid-stream: during the S sweep, rst is pulsed for one cycle at S=10 -> OUT=0x0000 for that cycle, then the sweep resumes with OUT=0x0800 for S=11.

Source files
------------

// File: rtl/mux_16_1_input16bit_pkg.sv
// Shared defaults for the registered 16:1 mux and its 4:1 building block.
package mux_16_1_input16bit_pkg;
  localparam int unsigned DEF_WIDTH = 16;
  localparam int unsigned DEF_SEL_W = 4;
  localparam int unsigned N_INPUTS  = 16;
endpackage

// File: rtl/mux_16_1_input16bit_mux_4_1.sv
// Combinational WIDTH-bit 4:1 mux; fully decoded on a 2-bit select.
module mux_4_1
  import mux_16_1_input16bit_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] i_d0,
  input  logic [WIDTH-1:0] i_d1,
  input  logic [WIDTH-1:0] i_d2,
  input  logic [WIDTH-1:0] i_d3,
  input  logic [1:0]       i_sel,
  output logic [WIDTH-1:0] o_y
);

  always_comb begin
    o_y = '0;
    unique case (i_sel)
      2'd0: o_y = i_d0;
      2'd1: o_y = i_d1;
      2'd2: o_y = i_d2;
      2'd3: o_y = i_d3;
    endcase
  end

endmodule

// File: rtl/mux_16_1_input16bit.sv
// Registered 16:1 mux built as a two-level tree of 4:1 muxes, one-cycle latency.
module mux_16_1_input16bit
  import mux_16_1_input16bit_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned SEL_W = DEF_SEL_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] X0,
  input  logic [WIDTH-1:0] X1,
  input  logic [WIDTH-1:0] X2,
  input  logic [WIDTH-1:0] X3,
  input  logic [WIDTH-1:0] X4,
  input  logic [WIDTH-1:0] X5,
  input  logic [WIDTH-1:0] X6,
  input  logic [WIDTH-1:0] X7,
  input  logic [WIDTH-1:0] X8,
  input  logic [WIDTH-1:0] X9,
  input  logic [WIDTH-1:0] X10,
  input  logic [WIDTH-1:0] X11,
  input  logic [WIDTH-1:0] X12,
  input  logic [WIDTH-1:0] X13,
  input  logic [WIDTH-1:0] X14,
  input  logic [WIDTH-1:0] X15,
  input  logic [SEL_W-1:0] S,
  output logic [WIDTH-1:0] OUT
);

  logic [WIDTH-1:0] w_x [N_INPUTS];
  logic [WIDTH-1:0] w_lvl1 [4];
  logic [WIDTH-1:0] w_sel;
  logic [WIDTH-1:0] r_out;

  assign w_x[0]  = X0;
  assign w_x[1]  = X1;
  assign w_x[2]  = X2;
  assign w_x[3]  = X3;
  assign w_x[4]  = X4;
  assign w_x[5]  = X5;
  assign w_x[6]  = X6;
  assign w_x[7]  = X7;
  assign w_x[8]  = X8;
  assign w_x[9]  = X9;
  assign w_x[10] = X10;
  assign w_x[11] = X11;
  assign w_x[12] = X12;
  assign w_x[13] = X13;
  assign w_x[14] = X14;
  assign w_x[15] = X15;

  // First level: group g covers inputs 4g..4g+3, picked by S[1:0].
  for (genvar g = 0; g < 4; g++) begin : g_lvl1
    mux_4_1 #(.WIDTH(WIDTH)) u_mux (
      .i_d0  (w_x[4*g+0]),
      .i_d1  (w_x[4*g+1]),
      .i_d2  (w_x[4*g+2]),
      .i_d3  (w_x[4*g+3]),
      .i_sel (S[1:0]),
      .o_y   (w_lvl1[g])
    );
  end

  mux_4_1 #(.WIDTH(WIDTH)) u_lvl2 (
    .i_d0  (w_lvl1[0]),
    .i_d1  (w_lvl1[1]),
    .i_d2  (w_lvl1[2]),
    .i_d3  (w_lvl1[3]),
    .i_sel (S[3:2]),
    .o_y   (w_sel)
  );

  always_ff @(posedge clk) begin
    if (rst) r_out <= '0;
    else     r_out <= w_sel;
  end

  assign OUT = r_out;

endmodule

// File: tb/tb_mux_16_1_input16bit.sv
// Directed-vector bench for the registered 16:1 mux.
module tb_mux_16_1_input16bit;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] x [16];
  logic [3:0]  s;
  logic [15:0] out;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  always #5 clk = ~clk;

  mux_16_1_input16bit #(.WIDTH(16), .SEL_W(4)) dut (
    .clk (clk),  .rst (rst),
    .X0  (x[0]),  .X1  (x[1]),  .X2  (x[2]),  .X3  (x[3]),
    .X4  (x[4]),  .X5  (x[5]),  .X6  (x[6]),  .X7  (x[7]),
    .X8  (x[8]),  .X9  (x[9]),  .X10 (x[10]), .X11 (x[11]),
    .X12 (x[12]), .X13 (x[13]), .X14 (x[14]), .X15 (x[15]),
    .S   (s),
    .OUT (out)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%04h, expected 0x%04h", tag, got, exp);
    end
  endtask

  // One rising edge, then sample 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_onehot();
    for (int i = 0; i < 16; i++) x[i] = 16'h0001 << i;
  endtask

  logic [3:0]  bb_sel [8] = '{4'd15, 4'd0, 4'd8, 4'd7, 4'd3, 4'd12, 4'd12, 4'd1};
  logic [15:0] bb_exp [8] = '{16'hFFFF, 16'h0000, 16'h8888, 16'h7777,
                              16'h3333, 16'hCCCC, 16'hCCCC, 16'h1111};

  initial begin
    rst = 1'b1;
    s   = 4'd3;
    for (int i = 0; i < 16; i++) x[i] = 16'h0000;
    x[3] = 16'h0008;

    // Reset overrides a live selection, then first edge after release loads normally.
    step();
    check("reset_out", out, 16'h0000);
    rst = 1'b0;
    step();
    check("post_reset", out, 16'h0008);

    // One-hot select sweep.
    load_onehot();
    for (int i = 0; i < 16; i++) begin
      s = 4'(i);
      step();
      check($sformatf("sweep_s%0d", i), out, 16'h0001 << i);
    end

    // Sweep with a one-cycle reset pulse at S=10.
    for (int i = 0; i < 16; i++) begin
      s   = 4'(i);
      rst = (i == 10);
      step();
      check($sformatf("rst_sweep_s%0d", i), out, (i == 10) ? 16'h0000 : (16'h0001 << i));
    end
    rst = 1'b0;

    // Unselected inputs toggle randomly while S=7 holds.
    s    = 4'd7;
    x[7] = 16'hA5A5;
    for (int c = 0; c < 8; c++) begin
      for (int i = 0; i < 16; i++) if (i != 7) x[i] = 16'($urandom);
      step();
      check($sformatf("isolate_c%0d", c), out, 16'hA5A5);
    end

    // Same-cycle change of select and data.
    s    = 4'd2;
    x[2] = 16'h1234;
    x[9] = 16'h0F0F;
    step();
    check("same_cyc_before", out, 16'h1234);
    s = 4'd9;
    for (int i = 0; i < 16; i++) x[i] = 16'h5A5A;
    x[9] = 16'hFFFF;
    step();
    check("same_cyc_after", out, 16'hFFFF);

    // Back-to-back select changes with nibble-replicated data (X[n] = 0xnnnn).
    for (int i = 0; i < 16; i++) x[i] = {4'(i), 4'(i), 4'(i), 4'(i)};
    for (int k = 0; k < 8; k++) begin
      s = bb_sel[k];
      step();
      check($sformatf("b2b_%0d", k), out, bb_exp[k]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
